dsp_mac_seq: RTL and testbench

- Sequencer for one dot-product DSP MAC slice (dual 8x18 multiply with a 27-bit accumulator).
- Accepts a vector length, streams operand beats into the MAC, and drives the accumulate and clock-enable controls.
- Waits out the MAC pipeline latency, then captures the 27-bit result into a valid/ready output register.
- Sits between the operand buffer/feeder and the DSP primitive; one vector in flight at a time.

---
 rtl/dsp_mac_seq_if.sv | 30 +++
 rtl/dsp_mac_seq.sv | 68 ++++++
 tb/tb_dsp_mac_seq.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_seq_if.sv
// dsp_mac_seq_if: command, operand stream, MAC port and result stream bundle for the MAC sequencer
interface dsp_mac_seq_if #(parameter int LEN_W = 10, parameter int RES_W = 27);
  logic start;
  logic [LEN_W-1:0] vec_len;
  logic busy;
  logic in_valid;
  logic in_ready;
  logic [7:0] in_ax;
  logic [17:0] in_bx;
  logic [7:0] in_ay;
  logic [17:0] in_by;
  logic [7:0] mac_ax;
  logic [17:0] mac_bx;
  logic [7:0] mac_ay;
  logic [17:0] mac_by;
  logic mac_accumulate;
  logic [2:0] mac_ena;
  logic [RES_W-1:0] mac_resulta;
  logic out_valid;
  logic out_ready;
  logic [RES_W-1:0] out_data;
  modport master (
    output start, vec_len, in_valid, in_ax, in_bx, in_ay, in_by, mac_resulta, out_ready,
    input busy, in_ready, mac_ax, mac_bx, mac_ay, mac_by, mac_accumulate, mac_ena, out_valid, out_data
  );
  modport slave (
    input start, vec_len, in_valid, in_ax, in_bx, in_ay, in_by, mac_resulta, out_ready,
    output busy, in_ready, mac_ax, mac_bx, mac_ay, mac_by, mac_accumulate, mac_ena, out_valid, out_data
  );
endinterface

// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: feeds one vector into a DSP MAC slice, drains its pipeline and holds the result
module dsp_mac_seq #(
  parameter int LAT = 3,
  parameter int LEN_W = 10,
  parameter int RES_W = 27
) (
  input logic clk0,
  input logic aclr0_n,
  dsp_mac_seq_if.slave bus
);
  localparam int CNT_W = LAT > 1 ? $clog2(LAT) : 1;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, HOLD} state_t;
  state_t state, state_n;
  logic [LEN_W-1:0] remaining;
  logic [CNT_W-1:0] cnt;
  logic first;
  logic [RES_W-1:0] data_q;
  logic feed, drain, beat;
  assign feed = state == FEED;
  assign drain = state == DRAIN;
  assign beat = feed & bus.in_valid;
  always_ff @(posedge clk0 or negedge aclr0_n) begin
    if (!aclr0_n) begin
      state <= IDLE;
      remaining <= '0;
      cnt <= '0;
      first <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        remaining <= bus.vec_len;
        first <= 1'b1;
        data_q <= '0;
      end
      if (beat) begin
        remaining <= remaining - 1'b1;
        first <= 1'b0;
        cnt <= CNT_W'(LAT - 1);
      end
      if (drain) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) data_q <= bus.mac_resulta;
      end
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (bus.start) state_n = bus.vec_len != '0 ? FEED : HOLD;
      FEED: if (bus.in_valid && remaining == LEN_W'(1)) state_n = DRAIN;
      DRAIN: if (cnt == '0) state_n = HOLD;
      HOLD: if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // a bubble freezes the whole MAC pipeline; draining adds zeros while the last beat ripples out
  assign bus.busy = state != IDLE;
  assign bus.in_ready = feed;
  assign bus.out_valid = state == HOLD;
  assign bus.out_data = data_q;
  assign bus.mac_ax = feed ? bus.in_ax : '0;
  assign bus.mac_bx = feed ? bus.in_bx : '0;
  assign bus.mac_ay = feed ? bus.in_ay : '0;
  assign bus.mac_by = feed ? bus.in_by : '0;
  assign bus.mac_ena = feed ? {3{bus.in_valid}} : drain ? 3'b111 : 3'b000;
  assign bus.mac_accumulate = feed ? ~first : drain;
endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: directed vector table plus hold and reset sequences against a behavioural MAC
module tb_dsp_mac_seq;
  localparam int LAT = 3;
  logic clk0 = 1'b0;
  logic aclr0_n = 1'b0;
  always #5 clk0 = ~clk0;
  dsp_mac_seq_if #(.LEN_W(10), .RES_W(27)) bus();
  dsp_mac_seq #(.LAT(LAT), .LEN_W(10), .RES_W(27)) dut (.clk0(clk0), .aclr0_n(aclr0_n), .bus(bus.slave));
  logic signed [26:0] acc, p0, p1, prod;
  assign prod = $signed(bus.mac_ax) * $signed(bus.mac_bx) + $signed(bus.mac_ay) * $signed(bus.mac_by);
  always_ff @(posedge clk0) begin
    if (bus.mac_ena == 3'b111) begin
      acc <= bus.mac_accumulate ? acc + prod : prod;
      p0 <= acc;
      p1 <= p0;
    end
  end
  assign bus.mac_resulta = p1;
  typedef struct {
    int len;
    logic [3:0][7:0] ax, ay;
    logic [3:0][17:0] bx, by;
    logic [3:0][1:0] gap;
    logic [26:0] exp;
  } vec_t;
  vec_t tv[5];
  vec_t v;
  int n_cmp = 0, n_err = 0, n;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk0);
    #1;
  endtask
  task automatic feed_one(input logic [7:0] ax, input logic [17:0] bx, input logic [7:0] ay, input logic [17:0] by);
    bus.start = 1'b1;
    bus.vec_len = 10'd1;
    step;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ax = ax;
    bus.in_bx = bx;
    bus.in_ay = ay;
    bus.in_by = by;
    step;
    bus.in_valid = 1'b0;
    n = 1;
    #2;
    while (!bus.out_valid && n < 20) begin
      step;
      #2;
      n++;
    end
    chk("one_latency", n, LAT + 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tv[0] = '{len: 4, ax: {8'd0, 8'd2, 8'd5, 8'd1}, bx: {18'd0, 18'd2, 18'd6, 18'd2},
              ay: {8'd0, 8'd2, 8'd7, 8'd3}, by: {18'd0, 18'd2, 18'd8, 18'd4}, gap: 8'h00, exp: 27'd108};
    tv[1] = tv[0];
    tv[1].gap = {2'd0, 2'd0, 2'd3, 2'd0};
    tv[2] = '{len: 1, ax: {8'd0, 8'd0, 8'd0, 8'd2}, bx: {18'd0, 18'd0, 18'd0, 18'd3},
              ay: 32'd0, by: 72'd0, gap: 8'h00, exp: 27'd6};
    tv[3] = '{len: 0, ax: 32'd0, bx: 72'd0, ay: 32'd0, by: 72'd0, gap: 8'h00, exp: 27'd0};
    tv[4] = '{len: 2, ax: {8'd0, 8'd0, 8'd2, 8'hFF}, bx: {18'd0, 18'd0, 18'd1, 18'd5},
              ay: 32'd0, by: 72'd0, gap: 8'h00, exp: 27'h7FFFFFD};
    bus.start = 1'b0;
    bus.vec_len = '0;
    bus.in_valid = 1'b0;
    bus.in_ax = 8'h11;
    bus.in_bx = '0;
    bus.in_ay = '0;
    bus.in_by = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_ena", bus.mac_ena, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_mac_ax", bus.mac_ax, 0);
    step;
    step;
    aclr0_n = 1'b1;
    step;
    for (int i = 0; i < 5; i++) begin
      v = tv[i];
      bus.start = 1'b1;
      bus.vec_len = 10'(v.len);
      #2;
      chk("idle_in_ready", bus.in_ready, 0);
      step;
      bus.start = 1'b0;
      if (v.len == 0) begin
        #2;
        chk("zero_out_valid", bus.out_valid, 1);
        chk("zero_out_data", bus.out_data, 0);
        chk("zero_ena", bus.mac_ena, 0);
      end else begin
        for (int b = 0; b < v.len; b++) begin
          for (int g = 0; g < int'(v.gap[b]); g++) begin
            bus.in_valid = 1'b0;
            #2;
            chk("gap_ena", bus.mac_ena, 0);
            chk("gap_in_ready", bus.in_ready, 1);
            step;
          end
          bus.in_valid = 1'b1;
          bus.in_ax = v.ax[b];
          bus.in_bx = v.bx[b];
          bus.in_ay = v.ay[b];
          bus.in_by = v.by[b];
          #2;
          chk("beat_ena", bus.mac_ena, 7);
          chk("beat_accumulate", bus.mac_accumulate, b != 0);
          chk("beat_mac_bx", bus.mac_bx, v.bx[b]);
          step;
        end
        bus.in_valid = 1'b0;
        n = 1;
        #2;
        while (!bus.out_valid && n < 20) begin
          chk("drain_ena", bus.mac_ena, 7);
          chk("drain_accumulate", bus.mac_accumulate, 1);
          step;
          #2;
          n++;
        end
        chk("latency", n, LAT + 1);
        chk("result", bus.out_data, v.exp);
      end
      bus.out_ready = 1'b1;
      step;
      bus.out_ready = 1'b0;
      #2;
      chk("post_busy", bus.busy, 0);
      chk("post_out_valid", bus.out_valid, 0);
    end
    feed_one(8'd2, 18'd3, 8'd0, 18'd0);
    for (int k = 0; k < 10; k++) begin
      bus.start = k[0];
      bus.vec_len = 10'd5;
      #2;
      chk("hold_data", bus.out_data, 6);
      chk("hold_busy", bus.busy, 1);
      chk("hold_valid", bus.out_valid, 1);
      step;
    end
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    step;
    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("hs_busy", bus.busy, 0);
    step;
    #2;
    chk("hs_start_ignored", bus.busy, 0);
    bus.start = 1'b1;
    bus.vec_len = 10'd4;
    step;
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ax = 8'd1;
    bus.in_bx = 18'd2;
    bus.in_ay = 8'd3;
    bus.in_by = 18'd4;
    step;
    bus.in_ax = 8'd5;
    bus.in_bx = 18'd6;
    bus.in_ay = 8'd7;
    bus.in_by = 18'd8;
    step;
    bus.in_valid = 1'b0;
    bus.in_ax = 8'h55;
    #2;
    aclr0_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_ena", bus.mac_ena, 0);
    chk("arst_mac_ax", bus.mac_ax, 0);
    chk("arst_accumulate", bus.mac_accumulate, 0);
    chk("arst_out_data", bus.out_data, 0);
    step;
    aclr0_n = 1'b1;
    step;
    #2;
    chk("arst_idle", bus.busy, 0);
    feed_one(8'd5, 18'd6, 8'd7, 18'd8);
    chk("fresh_result", bus.out_data, 86);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
